// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with optional idle gap between frames.
// Optional even-parity bit appended when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_PARITY, S_GAP
  } state_t;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_GAP
  } state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_gap;
  logic              r_ser_bit;
  logic              r_ser_valid;
  logic              r_frame_done;
`ifdef SER_PARITY_EN
  logic              r_par;
`endif

  logic              w_last;
  logic              w_accept;
  logic [DATA_W-1:0] w_nxt;

  function automatic logic pick(
    input logic [DATA_W-1:0] v
  );
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  assign w_nxt = (MSB_FIRST != 0)
               ? {r_shift[DATA_W-2:0], 1'b0}
               : {1'b0, r_shift[DATA_W-1:1]};

  assign w_last   = (r_state == S_SHIFT) && (r_cnt == '0);
  // Gapless reload only when no parity bit or gap follows the data.
  assign in_ready = (r_state == S_IDLE)
                 || (w_last && (GAP_CYCLES == 0) && !PAR_EN);
  assign w_accept = in_valid && in_ready;

  assign ser_bit    = r_ser_bit;
  assign ser_valid  = r_ser_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_ser_bit    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state      <= S_SHIFT;
      r_shift      <= in_data;
      r_cnt        <= CW'(DATA_W - 1);
      r_ser_bit    <= pick(in_data);
      r_ser_valid  <= 1'b1;
      r_frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      r_par        <= ^in_data;
`endif
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ser_bit   <= 1'b0;
          r_ser_valid <= 1'b0;
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_shift      <= w_nxt;
            r_ser_bit    <= pick(w_nxt);
            r_cnt        <= r_cnt - CW'(1);
            r_frame_done <= !PAR_EN && (r_cnt == CW'(1));
`ifdef SER_PARITY_EN
          end else begin
            r_state      <= S_PARITY;
            r_ser_bit    <= r_par;
            r_frame_done <= 1'b1;
          end
        end
        S_PARITY: begin
          begin
`else
          end else begin
`endif
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_gap   <= 4'(GAP_CYCLES - 1);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          r_ser_bit   <= 1'b0;
          r_ser_valid <= 1'b0;
          if (r_gap == '0) r_state <= S_IDLE;
          else             r_gap   <= r_gap - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default instance and an
// LSB-first instance with a two-cycle inter-frame gap.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d0 = '0, d1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, sb0, sv0, fd0, bz0;
  logic       rdy1, sb1, sv1, fd1, bz1;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bit_serializer u0 (
    .clk(clk), .reset(reset),
    .in_data(d0), .in_valid(v0), .in_ready(rdy0),
    .ser_bit(sb0), .ser_valid(sv0),
    .frame_done(fd0), .busy(bz0)
  );

  bit_serializer #(
    .DATA_W(8), .MSB_FIRST(0), .GAP_CYCLES(2)
  ) u1 (
    .clk(clk), .reset(reset),
    .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .ser_bit(sb1), .ser_valid(sv1),
    .frame_done(fd1), .busy(bz1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one word on u0 and check every bit of its frame.
  task automatic frame0(input string tag,
                        input logic [7:0] data,
                        input logic [8:0] stream,
                        input int len,
                        input bit rdy_last);
    d0 = data;
    v0 = 1'b1;
    chk({tag, "_acc"}, 32'(rdy0), 32'd1);
    tick;
    v0 = 1'b0;
    d0 = 8'hFF;
    for (int i = 1; i <= len; i++) begin
      chk($sformatf("%s_b%0d", tag, i),
          32'({sv0, sb0}), 32'({1'b1, stream[len-i]}));
      chk($sformatf("%s_fd%0d", tag, i),
          32'(fd0), 32'(i == len));
      chk($sformatf("%s_rdy%0d", tag, i),
          32'(rdy0), 32'(rdy_last && i == len));
      tick;
    end
    chk({tag, "_end"},
        32'({sv0, sb0, fd0, bz0, rdy0}), 32'(5'b00001));
  endtask

  initial begin
    tick;
    tick;
    chk("rst_u0", 32'({sv0, sb0, fd0, bz0, rdy0}), 32'(5'b00001));
    chk("rst_u1", 32'({sv1, sb1, fd1, bz1, rdy1}), 32'(5'b00001));
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("idle%0d", i),
          32'({sv0, bz0, rdy0}), 32'(3'b001));
      tick;
    end

`ifdef SER_PARITY_EN
    frame0("pD0", 8'hD0, 9'b110100001, 9, 1'b0);
    frame0("pC0", 8'hC0, 9'b110000000, 9, 1'b0);
`else
    frame0("D0", 8'hD0, 9'b011010000, 8, 1'b1);

    begin
      logic [15:0] s;
      s = 16'hD0B4;
      d0 = 8'hD0;
      v0 = 1'b1;
      tick;
      d0 = 8'hB4;
      for (int i = 1; i <= 16; i++) begin
        chk($sformatf("b2b_b%0d", i),
            32'({sv0, sb0}), 32'({1'b1, s[16-i]}));
        chk($sformatf("b2b_fd%0d", i),
            32'(fd0), 32'(i == 8 || i == 16));
        if (i == 9) v0 = 1'b0;
        tick;
      end
      chk("b2b_end", 32'({sv0, bz0}), 32'(2'b00));
    end
`endif

    begin
      logic [7:0] s;
      s = 8'b11010000;
      d1 = 8'h0B;
      v1 = 1'b1;
      chk("gap_acc", 32'(rdy1), 32'd1);
      tick;
      v1 = 1'b0;
      d1 = 8'hFF;
      for (int i = 1; i <= 8 + PE; i++) begin
        chk($sformatf("gap_b%0d", i), 32'({sv1, sb1}),
            32'({1'b1, (i <= 8) ? s[8-i] : 1'b1}));
        chk($sformatf("gap_fd%0d", i),
            32'(fd1), 32'(i == 8 + PE));
        chk($sformatf("gap_rdy%0d", i), 32'(rdy1), 32'd0);
        tick;
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gap_idle%0d", i),
            32'({sv1, sb1, fd1, rdy1, bz1}), 32'(5'b00001));
        tick;
      end
      chk("gap_done", 32'({sv1, rdy1, bz1}), 32'(3'b010));
    end

    d0 = 8'hFF;
    v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("abort_b%0d", i),
          32'({sv0, sb0, fd0}), 32'(3'b110));
      tick;
    end
    reset = 1'b1;
    tick;
    chk("abort_rst",
        32'({sv0, sb0, fd0, bz0, rdy0}), 32'(5'b00001));
    reset = 1'b0;
    d0 = 8'h81;
    v0 = 1'b1;
    chk("abort_rdy", 32'(rdy0), 32'd1);
    tick;
    v0 = 1'b0;
    chk("abort_new", 32'({sv0, sb0, bz0}), 32'(3'b111));
    tick;
    chk("abort_new2", 32'({sv0, sb0}), 32'(2'b10));
    for (int i = 0; i < 12; i++) tick;
    chk("abort_end", 32'({sv0, bz0, rdy0}), 32'(3'b001));

    reset = 1'b1;
    d0 = 8'hAA;
    v0 = 1'b1;
    tick;
    chk("prio_rst", 32'({sv0, bz0}), 32'(2'b00));
    reset = 1'b0;
    v0 = 1'b0;
    tick;
    chk("prio_after", 32'({sv0, bz0, rdy0}), 32'(3'b001));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8, shall set the parallel word width (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, shall select bit order: 1 = MSB first, 0 = LSB first.
REQ-003 Parameter GAP_CYCLES, default 0, shall set the idle cycles inserted after each frame (legal range 0..15).
REQ-004 clk  input  1  shall be the clock; all state shall update on its rising edge.
REQ-005 reset  input  1  shall be the reset: synchronous, active-high.
REQ-006 in_data  input  DATA_W  shall carry the parallel word to serialize.
REQ-007 in_valid  input  1  shall indicate that in_data is valid.
REQ-008 in_ready  output  1  shall indicate that the block accepts a word this cycle (combinational from state).
REQ-009 ser_bit  output  1  shall carry the serial bit stream to the downstream sequence detector (registered).
REQ-010 ser_valid  output  1  shall mark the cycles in which ser_bit is meaningful (registered).
REQ-011 frame_done  output  1  shall pulse high for one cycle, coincident with the last serial bit of a frame.
REQ-012 busy  output  1  shall be high whenever the state is not IDLE.

Function
REQ-013 The FSM shall have states IDLE, SHIFT, PARITY (only when SER_PARITY_EN is defined) and GAP.
REQ-014 A word shall be accepted on a rising edge where in_valid && in_ready; in_data shall be captured into the shift register at that edge.
REQ-015 in_ready shall be 1 in IDLE, and 1 in the final SHIFT cycle only if GAP_CYCLES==0 and parity is disabled; otherwise it shall be 0.
REQ-016 The first bit of an accepted word shall appear on ser_bit with ser_valid=1 in the cycle after acceptance (latency 1).
REQ-017 SHIFT shall present exactly DATA_W bits on consecutive cycles, in the order set by MSB_FIRST; a bit counter shall track the remaining bits.
REQ-018 After the final data bit: go to PARITY if enabled; else go to GAP if GAP_CYCLES>0; else go to SHIFT on an accepted word (gapless back-to-back) or to IDLE.
REQ-019 GAP shall hold ser_valid=0 for exactly GAP_CYCLES cycles and then enter IDLE.
REQ-020 When ser_valid=0, ser_bit shall be 0.
REQ-021 in_valid while in_ready=0 shall be ignored; in_data shall not be sampled.
REQ-022 frame_done shall be asserted on the last data bit, or on the parity bit when parity is enabled.

Reset
REQ-023 When reset is high at a rising edge: state=IDLE, bit counter=0, shift register=0, gap counter=0, ser_bit=0, ser_valid=0, frame_done=0, busy=0.
REQ-024 Reset asserted mid-frame shall abort the frame; no further bits of that word shall be emitted, and in_ready shall be 1 in the first cycle after reset deasserts.
REQ-025 reset shall take priority over a simultaneous handshake.

Configuration
REQ-026 Macro SER_PARITY_EN defined: PARITY shall emit one extra bit with ser_valid=1 after the data bits, equal to the XOR of all DATA_W bits (even parity); frames shall be DATA_W+1 bits long.
REQ-027 Macro SER_PARITY_EN undefined: the PARITY state and its logic shall be absent; frames shall be DATA_W bits long.

Verification
REQ-028 Defaults, accept 8'hD0 at cycle 0 -> ser_bit 1,1,0,1,0,0,0,0 in cycles 1..8 with ser_valid=1; frame_done only in cycle 8; in_ready=1 in cycle 8.
REQ-029 Defaults, in_valid held high with 8'hD0 then 8'hB4 -> 16 contiguous ser_valid cycles, with the second word starting in cycle 9 and no gap.
REQ-030 MSB_FIRST=0, GAP_CYCLES=2, 8'h0B -> ser_bit 1,1,0,1,0,0,0,0; ser_valid=0 and in_ready=0 in cycles 9..10; in_ready=1 in cycle 11.
REQ-031 reset pulsed in cycle 4 of a frame -> ser_valid=0 from the next cycle, no frame_done, and a new word is accepted in the first cycle after reset deasserts.
REQ-032 SER_PARITY_EN defined, 8'hD0 -> 9 valid bits with parity bit 1 in cycle 9; 8'hC0 -> parity bit 0; frame_done in cycle 9 in both cases.
REQ-033 in_valid=0 for 20 cycles after reset -> ser_valid=0, busy=0 and in_ready=1 throughout.
